// File: rtl/data_memory.sv
// Line-granular main data memory behind the dcache: fixed-latency whole-line
// reads and write-backs over an enable/ack handshake.
module data_memory #(
    parameter int LATENCY   = 10,
    parameter int DEPTH     = 512,
    parameter int LINE_BITS = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          addr_i,
    input  logic [LINE_BITS-1:0] data_i,
    input  logic                 enable_i,
    input  logic                 write_i,
    output logic                 ack_o,
    output logic [LINE_BITS-1:0] data_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } state_e;

    logic [LINE_BITS-1:0] memory [0:DEPTH-1];

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 wr_q, wr_d;
    logic [LINE_BITS-1:0] line_q, line_d;
    logic                 ack_q, ack_d;
    logic [LINE_BITS-1:0] rdata_q, rdata_d;
    logic                 accept;

    logic unused_addr;
    assign unused_addr = ^{addr_i[31:5+IDX_W], addr_i[4:0]};

    // A new request may be taken on the edge that ends the ack cycle, which
    // gives back-to-back transactions a period of LATENCY+1.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        line_d  = line_q;
        ack_d   = 1'b0;
        rdata_d = '0;
        accept  = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    accept = 1'b1;
                end
            end
            BUSY: begin
                count_d = count_q + 1'b1;
                if (count_q == CNT_W'(LATENCY - 1)) begin
                    state_d = ACK;
                    count_d = '0;
                    ack_d   = 1'b1;
                    if (!wr_q) begin
                        rdata_d = memory[idx_q];
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
                count_d = '0;
                if (enable_i) begin
                    accept = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase

        if (accept) begin
            state_d = BUSY;
            count_d = '0;
            idx_d   = addr_i[5 +: IDX_W];
            wr_d    = write_i;
            line_d  = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            line_q  <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            line_q  <= line_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    // Write-back commits on the edge ending the ack cycle; reset suppresses it.
    always_ff @(posedge clk_i) begin
        if (!rst_i && state_q == ACK && wr_q) begin
            memory[idx_q] <= line_q;
        end
    end

    assign ack_o  = ack_q;
    assign data_o = rdata_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: latency, line data, aliasing, mid-transaction
// reset and continuously held requests.
module tb_data_memory;

    logic         clk_i;
    logic         rst_i;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic         enable_i;
    logic         write_i;
    logic         ack_o;
    logic [255:0] data_o;

    int checks;
    int failures;

    localparam logic [255:0] MEM0  = 256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
    localparam logic [255:0] MEM1  = 256'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_7777_6666_5555_4444_3333_2222_1111_0000;
    localparam logic [255:0] MEM32 = 256'h0000_1001_2002_3003_4004_5005_6006_7007_8008_9009_A00A_B00B_C00C_D00D_E00E_F00F;
    localparam logic [255:0] MEM16 = {4{64'h0123_4567_89AB_CDEF}};
    localparam logic [255:0] MEM17 = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] ECFA  = {16{16'hECFA}};
    localparam logic [255:0] B2B   = {8{32'hC0FF_EE01}};

    data_memory dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .enable_i (enable_i),
        .write_i  (write_i),
        .ack_o    (ack_o),
        .data_o   (data_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Issues one request accepted at edge 0, then scrambles the inputs and
    // watches cycles 1..25 for the ack pulse.
    task automatic runTxn(input logic [31:0] addr, input logic [255:0] wdata, input logic wr,
                          output int ackCyc, output int ackCount,
                          output logic [255:0] rdata, output int offNonzero);
        enable_i = 1'b1;
        addr_i   = addr;
        data_i   = wdata;
        write_i  = wr;
        tick();
        enable_i = 1'b0;
        addr_i   = ~addr;
        data_i   = ~wdata;
        write_i  = ~wr;
        ackCyc     = -1;
        ackCount   = 0;
        rdata      = '0;
        offNonzero = 0;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (ack_o === 1'b1) begin
                ackCount++;
                if (ackCyc < 0) begin
                    ackCyc = c;
                    rdata  = data_o;
                end
            end else if (data_o !== '0) begin
                offNonzero++;
            end
        end
        addr_i  = '0;
        data_i  = '0;
        write_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_i    = 1'b1;
        enable_i = 1'b1;
        tick();
        tick();
        checks++;
        if (ack_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ack: got %b expected 0", ack_o);
        end
        checks++;
        if (data_o !== '0) begin
            failures++;
            $display("[TB] FAIL reset_data: got %h expected 0", data_o);
        end
        rst_i    = 1'b0;
        enable_i = 1'b0;
        tick();
    endtask

    task automatic test_read;
        int ackCyc, ackCount, offNz;
        logic [255:0] rdata;

        runTxn(32'h0000_0000, '0, 1'b0, ackCyc, ackCount, rdata, offNz);
        checks++;
        if (ackCyc !== 10) begin
            failures++;
            $display("[TB] FAIL read0_ack_cycle: got %0d expected 10", ackCyc);
        end
        checks++;
        if (ackCount !== 1) begin
            failures++;
            $display("[TB] FAIL read0_ack_width: got %0d expected 1", ackCount);
        end
        checks++;
        if (rdata !== MEM0) begin
            failures++;
            $display("[TB] FAIL read0_data: got %h expected %h", rdata, MEM0);
        end
        checks++;
        if (offNz !== 0) begin
            failures++;
            $display("[TB] FAIL read0_data_zero_off_ack: got %0d nonzero cycles expected 0", offNz);
        end

        runTxn(32'h0000_0020, '0, 1'b0, ackCyc, ackCount, rdata, offNz);
        checks++;
        if (ackCyc !== 10) begin
            failures++;
            $display("[TB] FAIL read1_ack_cycle: got %0d expected 10", ackCyc);
        end
        checks++;
        if (rdata !== MEM1) begin
            failures++;
            $display("[TB] FAIL read1_data: got %h expected %h", rdata, MEM1);
        end

        runTxn(32'h0000_0400, '0, 1'b0, ackCyc, ackCount, rdata, offNz);
        checks++;
        if (ackCyc !== 10) begin
            failures++;
            $display("[TB] FAIL read32_ack_cycle: got %0d expected 10", ackCyc);
        end
        checks++;
        if (rdata !== MEM32) begin
            failures++;
            $display("[TB] FAIL read32_data: got %h expected %h", rdata, MEM32);
        end
    endtask

    task automatic test_write;
        int ackCyc, ackCount, offNz;
        logic [255:0] rdata;

        runTxn(32'h0000_0240, ECFA, 1'b1, ackCyc, ackCount, rdata, offNz);
        checks++;
        if (ackCyc !== 10) begin
            failures++;
            $display("[TB] FAIL write18_ack_cycle: got %0d expected 10", ackCyc);
        end
        checks++;
        if (dut.memory[18] !== ECFA) begin
            failures++;
            $display("[TB] FAIL write18_mem: got %h expected %h", dut.memory[18], ECFA);
        end
        checks++;
        if (dut.memory[17] !== MEM17) begin
            failures++;
            $display("[TB] FAIL write18_neighbour17: got %h expected %h", dut.memory[17], MEM17);
        end
        checks++;
        if (dut.memory[16] !== MEM16) begin
            failures++;
            $display("[TB] FAIL write18_neighbour16: got %h expected %h", dut.memory[16], MEM16);
        end

        runTxn(32'h0000_0240, '0, 1'b0, ackCyc, ackCount, rdata, offNz);
        checks++;
        if (rdata !== ECFA) begin
            failures++;
            $display("[TB] FAIL write18_readback: got %h expected %h", rdata, ECFA);
        end
    endtask

    task automatic test_alias;
        int ackCyc, ackCount, offNz;
        logic [255:0] rdata;

        runTxn(32'h0000_4000, 256'h1, 1'b1, ackCyc, ackCount, rdata, offNz);
        checks++;
        if (dut.memory[0] !== 256'h1) begin
            failures++;
            $display("[TB] FAIL alias_write_mem0: got %h expected 1", dut.memory[0]);
        end

        runTxn(32'h0000_001F, '0, 1'b0, ackCyc, ackCount, rdata, offNz);
        checks++;
        if (rdata !== 256'h1) begin
            failures++;
            $display("[TB] FAIL alias_low_bits_read: got %h expected 1", rdata);
        end
    endtask

    task automatic test_mid_reset;
        int ackCount, ackCyc, dummyCount, offNz;
        logic [255:0] rdata;

        enable_i = 1'b1;
        addr_i   = 32'h0000_0200;
        data_i   = {16{16'h5A5A}};
        write_i  = 1'b1;
        tick();
        enable_i = 1'b0;
        ackCount = 0;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (ack_o === 1'b1) ackCount++;
            if (c == 5) rst_i = 1'b1;
            if (c == 6) rst_i = 1'b0;
        end
        write_i = 1'b0;
        checks++;
        if (ackCount !== 0) begin
            failures++;
            $display("[TB] FAIL midreset_no_ack: got %0d pulses expected 0", ackCount);
        end
        checks++;
        if (dut.memory[16] !== MEM16) begin
            failures++;
            $display("[TB] FAIL midreset_mem16: got %h expected %h", dut.memory[16], MEM16);
        end

        runTxn(32'h0000_0200, '0, 1'b0, ackCyc, dummyCount, rdata, offNz);
        checks++;
        if (ackCyc !== 10) begin
            failures++;
            $display("[TB] FAIL midreset_next_ack_cycle: got %0d expected 10", ackCyc);
        end
        checks++;
        if (rdata !== MEM16) begin
            failures++;
            $display("[TB] FAIL midreset_next_data: got %h expected %h", rdata, MEM16);
        end
    endtask

    // Write line 40 then switch to reads with enable held high throughout.
    task automatic test_back_to_back;
        int ackCycles[$];
        int consecutive;
        logic prevAck;
        logic [255:0] data21, data32;

        consecutive = 0;
        prevAck     = 1'b0;
        data21      = '0;
        data32      = '0;
        enable_i    = 1'b1;
        addr_i      = 32'h0000_0500;
        data_i      = B2B;
        write_i     = 1'b1;
        tick();
        for (int c = 1; c <= 45; c++) begin
            tick();
            if (ack_o === 1'b1) begin
                ackCycles.push_back(c);
                if (prevAck) consecutive++;
                if (c == 21) data21 = data_o;
                if (c == 32) data32 = data_o;
            end
            prevAck = (ack_o === 1'b1);
            if (c == 10) begin
                write_i = 1'b0;
                data_i  = '0;
            end
            if (c == 32) enable_i = 1'b0;
        end

        checks++;
        if (ackCycles.size() !== 3) begin
            failures++;
            $display("[TB] FAIL b2b_pulse_count: got %0d expected 3", ackCycles.size());
        end
        checks++;
        if (ackCycles.size() < 1 || ackCycles[0] !== 10) begin
            failures++;
            $display("[TB] FAIL b2b_first_ack: got %0d expected 10",
                     ackCycles.size() > 0 ? ackCycles[0] : -1);
        end
        checks++;
        if (ackCycles.size() < 2 || ackCycles[1] !== 21) begin
            failures++;
            $display("[TB] FAIL b2b_second_ack: got %0d expected 21",
                     ackCycles.size() > 1 ? ackCycles[1] : -1);
        end
        checks++;
        if (ackCycles.size() < 3 || ackCycles[2] !== 32) begin
            failures++;
            $display("[TB] FAIL b2b_third_ack: got %0d expected 32",
                     ackCycles.size() > 2 ? ackCycles[2] : -1);
        end
        checks++;
        if (consecutive !== 0) begin
            failures++;
            $display("[TB] FAIL b2b_ack_two_cycles: got %0d expected 0", consecutive);
        end
        checks++;
        if (data21 !== B2B) begin
            failures++;
            $display("[TB] FAIL b2b_write_then_read: got %h expected %h", data21, B2B);
        end
        checks++;
        if (data32 !== B2B) begin
            failures++;
            $display("[TB] FAIL b2b_second_read: got %h expected %h", data32, B2B);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_i    = 1'b1;
        enable_i = 1'b0;
        write_i  = 1'b0;
        addr_i   = '0;
        data_i   = '0;
        dut.memory[0]  = MEM0;
        dut.memory[1]  = MEM1;
        dut.memory[16] = MEM16;
        dut.memory[17] = MEM17;
        dut.memory[18] = '0;
        dut.memory[32] = MEM32;
        dut.memory[40] = '0;

        test_reset();
        test_read();
        test_write();
        test_alias();
        test_mid_reset();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
